l2_cache_update: RTL

Final L2 cache pipeline stage, consuming the data-read stage's outputs. It:
- merges store data into the line just read (or into fill data from memory);
- drives the cache data SRAM write port (`wr_update_*`) back to the read stage;
- forwards its own previous-cycle write to close the SRAM read-during-write hazard;
- registers the response and dirty-writeback information for the response/SMI logic.

---
 rtl/l2_cache_update.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/l2_cache_update.sv
// l2_cache_update: final L2 pipeline stage. Merges store data, drives the data SRAM write port,
// forwards the previous write, registers response/writeback info. L2_UPDATE_PERF_EN adds counters.
`ifndef CACHE_LINE_BITS
`define CACHE_LINE_BITS 512
`endif
`ifndef L2_SET_INDEX_WIDTH
`define L2_SET_INDEX_WIDTH 5
`endif
`ifndef L2_WAY_INDEX_WIDTH
`define L2_WAY_INDEX_WIDTH 3
`endif
`ifndef L2_CACHE_ADDR_WIDTH
`define L2_CACHE_ADDR_WIDTH (`L2_WAY_INDEX_WIDTH + `L2_SET_INDEX_WIDTH)
`endif
`ifndef L2_TAG_WIDTH
`define L2_TAG_WIDTH (26 - `L2_SET_INDEX_WIDTH)
`endif

package l2_cache_update_pkg;
    localparam int LINE_BITS    = `CACHE_LINE_BITS;
    localparam int LINE_BYTES   = LINE_BITS / 8;
    localparam int ADDR_W       = 26;
    localparam int CACHE_ADDR_W = `L2_CACHE_ADDR_WIDTH;
    localparam int SET_W        = `L2_SET_INDEX_WIDTH;
    localparam int TAG_W        = `L2_TAG_WIDTH;

    typedef enum logic [2:0] {
        L2REQ_LOAD       = 3'd0,
        L2REQ_STORE      = 3'd1,
        L2REQ_FLUSH      = 3'd2,
        L2REQ_INVALIDATE = 3'd3,
        L2REQ_LOAD_SYNC  = 3'd4,
        L2REQ_STORE_SYNC = 3'd5
    } l2req_op_t;

    typedef struct packed {
        logic                  valid;
        l2req_op_t             op;
        logic [1:0]            core;
        logic [1:0]            strand;
        logic [ADDR_W-1:0]     address;
        logic [LINE_BITS-1:0]  data;
        logic [LINE_BYTES-1:0] mask;
    } l2req_packet_t;
endpackage

module l2_cache_update
    import l2_cache_update_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  l2req_packet_t           rd_l2req_packet,
    input  logic                    rd_is_l2_fill,
    input  logic                    rd_cache_hit,
    input  logic                    rd_store_sync_success,
    input  logic                    rd_line_is_dirty,
    input  logic [LINE_BITS-1:0]    rd_data_from_memory,
    input  logic [LINE_BITS-1:0]    rd_cache_mem_result,
    input  logic [CACHE_ADDR_W-1:0] rd_cache_index,
    input  logic [TAG_W-1:0]        rd_old_l2_tag,
    output logic                    wr_update_enable,
    output logic [CACHE_ADDR_W-1:0] wr_cache_write_index,
    output logic [LINE_BITS-1:0]    wr_update_data,
    output l2req_packet_t           wr_l2req_packet,
    output logic [LINE_BITS-1:0]    wr_data,
    output logic                    wr_cache_hit,
    output logic                    wr_is_l2_fill,
    output logic                    wr_store_sync_success,
    output logic                    wr_writeback_en,
    output logic [ADDR_W-1:0]       wr_writeback_address,
    output logic [LINE_BITS-1:0]    wr_writeback_data
`ifdef L2_UPDATE_PERF_EN
    ,
    output logic [31:0]             perf_hit_count,
    output logic [31:0]             perf_miss_count,
    output logic [31:0]             perf_writeback_count
`endif
);

    logic                    bypass_valid_q;
    logic [CACHE_ADDR_W-1:0] bypass_index_q;
    logic [LINE_BITS-1:0]    bypass_data_q;

    logic [LINE_BITS-1:0]    old_line;
    logic [LINE_BITS-1:0]    base_line;
    logic [LINE_BITS-1:0]    merged_line;
    logic [LINE_BITS-1:0]    update_data;
    logic                    is_store;
    logic                    update_en;
    logic                    writeback_d;
    logic [ADDR_W-1:0]       writeback_addr_d;

    l2req_packet_t           pkt_q;
    logic [LINE_BITS-1:0]    data_q;
    logic                    cache_hit_q;
    logic                    is_fill_q;
    logic                    sync_success_q;
    logic                    writeback_en_q;
    logic [ADDR_W-1:0]       writeback_addr_q;
    logic [LINE_BITS-1:0]    writeback_data_q;

    always_comb begin
        // The SRAM has not yet absorbed last cycle's write; take it from the bypass register.
        old_line = (bypass_valid_q && (bypass_index_q == rd_cache_index))
                   ? bypass_data_q : rd_cache_mem_result;
        base_line = rd_is_l2_fill ? rd_data_from_memory : old_line;

        merged_line = base_line;
        for (int i = 0; i < LINE_BYTES; i++) begin
            if (rd_l2req_packet.mask[i]) begin
                merged_line[8*i +: 8] = rd_l2req_packet.data[8*i +: 8];
            end
        end

        is_store = (rd_l2req_packet.op == L2REQ_STORE)
                || ((rd_l2req_packet.op == L2REQ_STORE_SYNC) && rd_store_sync_success);
        update_en = reset && rd_l2req_packet.valid
                 && (rd_is_l2_fill || (rd_cache_hit && is_store));
        update_data = is_store ? merged_line : base_line;

        writeback_d = rd_l2req_packet.valid && rd_line_is_dirty
                   && (rd_is_l2_fill || ((rd_l2req_packet.op == L2REQ_FLUSH) && rd_cache_hit));
        writeback_addr_d = rd_is_l2_fill
                         ? {rd_old_l2_tag, rd_cache_index[SET_W-1:0]}
                         : rd_l2req_packet.address;
    end

    assign wr_update_enable     = update_en;
    assign wr_cache_write_index = rd_cache_index;
    assign wr_update_data       = update_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bypass_valid_q   <= 1'b0;
            bypass_index_q   <= '0;
            bypass_data_q    <= '0;
            pkt_q            <= '0;
            data_q           <= '0;
            cache_hit_q      <= 1'b0;
            is_fill_q        <= 1'b0;
            sync_success_q   <= 1'b0;
            writeback_en_q   <= 1'b0;
            writeback_addr_q <= '0;
            writeback_data_q <= '0;
        end else begin
            bypass_valid_q <= update_en;
            if (update_en) begin
                bypass_index_q <= rd_cache_index;
                bypass_data_q  <= update_data;
            end
            pkt_q            <= rd_l2req_packet;
            data_q           <= update_en ? update_data : old_line;
            cache_hit_q      <= rd_cache_hit;
            is_fill_q        <= rd_is_l2_fill;
            sync_success_q   <= rd_l2req_packet.valid && rd_store_sync_success;
            writeback_en_q   <= writeback_d;
            writeback_addr_q <= writeback_addr_d;
            writeback_data_q <= old_line;
        end
    end

    assign wr_l2req_packet       = pkt_q;
    assign wr_data               = data_q;
    assign wr_cache_hit          = cache_hit_q;
    assign wr_is_l2_fill         = is_fill_q;
    assign wr_store_sync_success = sync_success_q;
    assign wr_writeback_en       = writeback_en_q;
    assign wr_writeback_address  = writeback_addr_q;
    assign wr_writeback_data     = writeback_data_q;

`ifdef L2_UPDATE_PERF_EN
    logic [31:0] perf_hit_q;
    logic [31:0] perf_miss_q;
    logic [31:0] perf_wb_q;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_hit_q  <= '0;
            perf_miss_q <= '0;
            perf_wb_q   <= '0;
        end else if (rd_l2req_packet.valid) begin
            if (rd_cache_hit && (perf_hit_q != '1)) begin
                perf_hit_q <= perf_hit_q + 32'd1;
            end
            if (!rd_cache_hit && !rd_is_l2_fill && (perf_miss_q != '1)) begin
                perf_miss_q <= perf_miss_q + 32'd1;
            end
            if (writeback_d && (perf_wb_q != '1)) begin
                perf_wb_q <= perf_wb_q + 32'd1;
            end
        end
    end

    assign perf_hit_count       = perf_hit_q;
    assign perf_miss_count      = perf_miss_q;
    assign perf_writeback_count = perf_wb_q;
`endif

endmodule
